// File: rtl/fir_sym_serial_if.sv
// Sample, result and coefficient-load signals of the serial symmetric FIR.
// master = producer/controller side, slave = filter side.
interface fir_sym_serial_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 13,
    parameter int OUT_W  = 16,
    parameter int AW     = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     sat_flag;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_swap;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_wdata, coef_swap,
        input  in_ready, out_valid, out_data, sat_flag
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_wdata, coef_swap,
        output in_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/fir_sym_serial.sv
// Time-multiplexed linear-phase FIR: one pre-adder and one multiplier walk the
// HALF coefficient pairs, then the sum is rounded half-up and saturated.
module fir_sym_serial #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 13,
    parameter int TAPS      = 63,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 19,
    parameter int OUT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    fir_sym_serial_if.slave bus
);
    localparam int HALF = (TAPS + 1) / 2;
    localparam int AW   = $clog2(HALF);
    localparam int PW   = DATA_W + 1;
    localparam int MW   = PW + COEF_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] RND  = 2'd2;

    localparam logic signed [ACC_W:0]   RND_BIAS = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    localparam logic signed [OUT_W-1:0] OMAX_O   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OMIN_O   = ~OMAX_O;
    localparam logic signed [ACC_W:0]   OMAX     = (ACC_W+1)'(OMAX_O);
    localparam logic signed [ACC_W:0]   OMIN     = (ACC_W+1)'(OMIN_O);

    logic [1:0]                     state;
    logic [TAPS-1:0][DATA_W-1:0]    dly;      // dly[0] is the newest sample
    logic [HALF-1:0][COEF_W-1:0]    shadow;
    logic [HALF-1:0][COEF_W-1:0]    active;
    logic [AW-1:0]                  k;
    logic signed [ACC_W-1:0]        acc;
    logic                           swap_pending;
    logic                           ov;
    logic signed [OUT_W-1:0]        od;
    logic                           sf;

    logic signed [PW-1:0]     pre [HALF];
    logic signed [PW-1:0]     pre_k;
    logic signed [COEF_W-1:0] coef_k;
    logic signed [MW-1:0]     prod;
    logic signed [ACC_W:0]    rsum;
    logic signed [ACC_W:0]    rsh;
    logic                     sat_hi;
    logic                     sat_lo;
    logic signed [OUT_W-1:0]  rclamp;

    // Pair k folds the mirrored taps; the centre tap has no partner.
    for (genvar i = 0; i < HALF; i++) begin : g_pre
        if (i == HALF - 1) begin : g_ctr
            assign pre[i] = PW'($signed(dly[i]));
        end else begin : g_pair
            assign pre[i] = PW'($signed(dly[i])) + PW'($signed(dly[TAPS-1-i]));
        end
    end

    assign pre_k  = pre[k];
    assign coef_k = $signed(active[k]);
    assign prod   = MW'(pre_k) * MW'(coef_k);

    // One guard bit keeps the rounding bias from wrapping a near-full accumulator.
    assign rsum   = (ACC_W+1)'(acc) + RND_BIAS;
    assign rsh    = rsum >>> OUT_SHIFT;
    assign sat_hi = rsh > OMAX;
    assign sat_lo = rsh < OMIN;
    assign rclamp = sat_hi ? OMAX_O : (sat_lo ? OMIN_O : rsh[OUT_W-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            dly          <= '0;
            shadow       <= '0;
            active       <= '0;
            acc          <= '0;
            k            <= '0;
            swap_pending <= 1'b0;
            ov           <= 1'b0;
            od           <= '0;
            sf           <= 1'b0;
        end else begin
            ov <= 1'b0;
            if (bus.coef_we && 32'(bus.coef_addr) < HALF)
                shadow[bus.coef_addr] <= bus.coef_wdata;
            // Bank copy only in IDLE, so a running MAC never sees a mixed bank.
            if (state == IDLE && swap_pending) begin
                active       <= shadow;
                swap_pending <= 1'b0;
            end else if (bus.coef_swap) begin
                swap_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dly   <= {dly[TAPS-2:0], bus.in_data};
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    k   <= k + 1'b1;
                    if (k == AW'(HALF - 1))
                        state <= RND;
                end
                RND: begin
                    ov    <= 1'b1;
                    od    <= rclamp;
                    sf    <= sat_hi | sat_lo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign bus.sat_flag  = sf;
endmodule
